// File: rtl/prm_register_rs_pkg.sv
// prm_register_rs_pkg: occupancy width shared by the register slice and its users
package prm_register_rs_pkg;
  localparam int CNT_W = 2;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/prm_register_sr.sv
// prm_register_sr: WIDTH-bit data register with enable (clk, rst, en, d -> q), sync reset to 0
module prm_register_sr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/prm_register_rs.sv
// prm_register_rs: 2-entry skid register slice on a valid/ready stream with registered in_ready/out_valid/out_data/count
module prm_register_rs
  import prm_register_rs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output cnt_t             count
);
  typedef enum logic [CNT_W-1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, nxt;
  logic push, pop, main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  always_comb begin
    nxt = state == EMPTY ? (push ? ONE : EMPTY)
        : state == ONE   ? (push & ~pop ? TWO : (~push & pop ? EMPTY : ONE))
        :                  (pop ? ONE : TWO);
    main_en = state == EMPTY ? push : state == ONE ? push & pop : pop;
    skid_en = state == ONE & push & ~pop;
    main_d  = state == TWO ? skid_q : in_data;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      state     <= nxt;
      in_ready  <= nxt != TWO;
      out_valid <= nxt != EMPTY;
      count     <= nxt;
    end
  prm_register_sr #(.WIDTH(WIDTH)) u_main (.clk(clk), .rst(rst), .en(main_en), .d(main_d),  .q(out_data));
  prm_register_sr #(.WIDTH(WIDTH)) u_skid (.clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid_q));
endmodule
